// File: rtl/ram_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// ram_arbiter_pkg
//
// Shared definitions for the two-port RAM arbiter:
//   - arb_state_t : FSM state codes (IDLE=00, ISSUE=01, WAIT_RD=10, ACK=11)
//   - PORT0/PORT1 : requester id constants
//   - LAT_CNT_W   : width of the read-latency down-counter (RD_LAT is 1..7)
//   - lat_reload  : value loaded into the down-counter when a read is issued
//
// No ports; imported with "import ram_arbiter_pkg::*;".
// ----------------------------------------------------------------------------
package ram_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ISSUE   = 2'b01,
        ST_WAIT_RD = 2'b10,
        ST_ACK     = 2'b11
    } arb_state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    localparam int LAT_CNT_W = 3;

    // The counter runs RD_LAT-1 down to 0, so WAIT_RD lasts exactly RD_LAT cycles.
    function automatic logic [LAT_CNT_W-1:0] lat_reload(input int rd_lat);
        return LAT_CNT_W'(rd_lat - 1);
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// ----------------------------------------------------------------------------
// ram_arbiter_if
//
// One requester port of the RAM arbiter.
//   req   : request, held by the requester until ack
//   we    : 1 = write, 0 = read
//   addr  : RAM word address (ADDR_W bits)
//   wdata : write data (DATA_W bits)
//   ack   : one-cycle completion pulse from the arbiter
//   rdata : read data, valid while ack is high, held until the next read
//
// Modports:
//   master : requester side (drives req/we/addr/wdata)
//   slave  : arbiter side   (drives ack/rdata)
// ----------------------------------------------------------------------------
interface ram_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) ();

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, rdata
    );

endinterface

// File: rtl/arb_rr_pick.sv
// ----------------------------------------------------------------------------
// arb_rr_pick
//
// Combinational 2-way grant picker for the RAM arbiter.
//   req[1:0]   : in  - request vector, bit 0 = port 0, bit 1 = port 1
//   last_grant : in  - id of the port granted most recently
//   gnt_valid  : out - at least one port is requesting
//   gnt_id     : out - id of the port to grant (meaningful when gnt_valid)
//
// Build option ARB_FIXED_PRIO_EN:
//   undefined (default) : round-robin, a tie goes to the port != last_grant
//   defined             : fixed priority, port 0 always wins a tie
// ----------------------------------------------------------------------------
module arb_rr_pick
    import ram_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt_valid,
    output logic       gnt_id
);

    // With no request the id is a don't-care; echoing last_grant keeps
    // last_grant referenced in the fixed-priority build as well.
    always_comb begin
        gnt_valid = |req;
        gnt_id    = last_grant;
`ifdef ARB_FIXED_PRIO_EN
        if (req[0]) begin
            gnt_id = PORT0;
        end else if (req[1]) begin
            gnt_id = PORT1;
        end
`else
        case (req)
            2'b01:   gnt_id = PORT0;
            2'b10:   gnt_id = PORT1;
            2'b11:   gnt_id = ~last_grant;
            default: gnt_id = last_grant;
        endcase
`endif
    end

endmodule

// File: rtl/ram_arbiter.sv
// ----------------------------------------------------------------------------
// ram_arbiter
//
// Shares a single synchronous RAM port between two requesters (port 0: CPU
// control unit, port 1: auxiliary master). One transaction is latched per
// grant, driven onto the RAM, and completed with a one-cycle ack pulse.
//
// Parameters:
//   RAM_SIZE : RAM address width in bits
//   DATA_W   : data word width
//   RD_LAT   : RAM read latency in cycles, legal range 1..7
//
// Ports:
//   clk         : in  - system clock, rising edge
//   rst         : in  - synchronous active-high reset
//   m0, m1      : ram_arbiter_if.slave requester ports 0 and 1
//   ram_address : out - RAM address
//   we          : out - RAM write enable (high only in ISSUE of a write)
//   ram_out     : out - RAM write data
//   ram_in      : in  - RAM read data
//   busy        : out - high whenever the FSM is not IDLE
//
// Latency from req sampled in IDLE: write ack after 2 cycles,
// read ack after 2+RD_LAT cycles.
//
// Build option ARB_FIXED_PRIO_EN selects fixed priority (port 0 wins ties)
// instead of round-robin; see arb_rr_pick.
// ----------------------------------------------------------------------------
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int RAM_SIZE = 16,
    parameter int DATA_W   = 16,
    parameter int RD_LAT   = 1
) (
    input  logic                clk,
    input  logic                rst,
    ram_arbiter_if.slave        m0,
    ram_arbiter_if.slave        m1,
    output logic [RAM_SIZE-1:0] ram_address,
    output logic                we,
    output logic [DATA_W-1:0]   ram_out,
    input  logic [DATA_W-1:0]   ram_in,
    output logic                busy
);

    localparam logic [LAT_CNT_W-1:0] LAT_INIT = lat_reload(RD_LAT);

    arb_state_t           state;
    logic                 last_grant;
    logic                 cur_id;
    logic                 cur_we;
    logic [LAT_CNT_W-1:0] lat_cnt;
    logic                 ack0;
    logic                 ack1;
    logic [DATA_W-1:0]    rdata0;
    logic [DATA_W-1:0]    rdata1;

    logic                 gnt_valid;
    logic                 gnt_id;

    arb_rr_pick u_pick (
        .req        ({m1.req, m0.req}),
        .last_grant (last_grant),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    // The arbiter's outputs are all registers; the interface signals and
    // busy simply expose them.
    assign m0.ack   = ack0;
    assign m1.ack   = ack1;
    assign m0.rdata = rdata0;
    assign m1.rdata = rdata1;
    assign busy     = (state != ST_IDLE);

    // Single-process FSM. The RAM address/data/we registers double as the
    // latched copy of the granted transaction: they are loaded at the grant
    // edge so the RAM sees them exactly during ISSUE, and address/data simply
    // hold afterwards. Requester inputs are only looked at in IDLE, so
    // anything a requester does after being granted is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            last_grant  <= PORT1;
            cur_id      <= PORT0;
            cur_we      <= 1'b0;
            lat_cnt     <= '0;
            ram_address <= '0;
            we          <= 1'b0;
            ram_out     <= '0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            rdata0      <= '0;
            rdata1      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt_valid) begin
                        cur_id     <= gnt_id;
                        last_grant <= gnt_id;
                        if (gnt_id == PORT1) begin
                            cur_we      <= m1.we;
                            we          <= m1.we;
                            ram_address <= m1.addr;
                            ram_out     <= m1.wdata;
                        end else begin
                            cur_we      <= m0.we;
                            we          <= m0.we;
                            ram_address <= m0.addr;
                            ram_out     <= m0.wdata;
                        end
                        state <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    we <= 1'b0;
                    if (cur_we) begin
                        ack0  <= (cur_id == PORT0);
                        ack1  <= (cur_id == PORT1);
                        state <= ST_ACK;
                    end else begin
                        lat_cnt <= LAT_INIT;
                        state   <= ST_WAIT_RD;
                    end
                end

                ST_WAIT_RD: begin
                    if (lat_cnt == '0) begin
                        if (cur_id == PORT1) begin
                            rdata1 <= ram_in;
                        end else begin
                            rdata0 <= ram_in;
                        end
                        ack0  <= (cur_id == PORT0);
                        ack1  <= (cur_id == PORT1);
                        state <= ST_ACK;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end

                ST_ACK: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ram_arbiter
//
// Directed bench for ram_arbiter. Two instances are exercised: u_dut1 with
// RD_LAT=1 and u_dut3 with RD_LAT=3, each with its own small RAM model.
// Cycle index k counts falling edges after the rising edge that first
// samples a request, so an ack "at t+N" is first visible at k=N.
// ----------------------------------------------------------------------------
module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    ram_arbiter_if #(.ADDR_W(16), .DATA_W(16)) a0 ();
    ram_arbiter_if #(.ADDR_W(16), .DATA_W(16)) a1 ();
    ram_arbiter_if #(.ADDR_W(16), .DATA_W(16)) b0 ();
    ram_arbiter_if #(.ADDR_W(16), .DATA_W(16)) b1 ();

    logic [15:0] ram_address1, ram_out1, ram_in1;
    logic        we1, busy1;
    logic [15:0] ram_address3, ram_out3, ram_in3;
    logic        we3, busy3;

    int errors = 0;
    int checks = 0;

    ram_arbiter #(.RAM_SIZE(16), .DATA_W(16), .RD_LAT(1)) u_dut1 (
        .clk         (clk),
        .rst         (rst),
        .m0          (a0),
        .m1          (a1),
        .ram_address (ram_address1),
        .we          (we1),
        .ram_out     (ram_out1),
        .ram_in      (ram_in1),
        .busy        (busy1)
    );

    ram_arbiter #(.RAM_SIZE(16), .DATA_W(16), .RD_LAT(3)) u_dut3 (
        .clk         (clk),
        .rst         (rst),
        .m0          (b0),
        .m1          (b1),
        .ram_address (ram_address3),
        .we          (we3),
        .ram_out     (ram_out3),
        .ram_in      (ram_in3),
        .busy        (busy3)
    );

    // RAM model for u_dut1: 256 words, synchronous write, 1-cycle read.
    logic [15:0] mem1 [0:255];
    always @(posedge clk) begin
        if (we1) mem1[ram_address1[7:0]] <= ram_out1;
        ram_in1 <= mem1[ram_address1[7:0]];
    end

    // RAM model for u_dut3: read-only contents, 3-stage read pipeline.
    logic [15:0] val10;
    logic [15:0] rd3_word;
    logic [15:0] pipe3 [0:2];
    always_comb begin
        case (ram_address3)
            16'h0010: rd3_word = val10;
            16'h0011: rd3_word = 16'hDEAD;
            default:  rd3_word = 16'h0000;
        endcase
    end
    always @(posedge clk) begin
        pipe3[0] <= rd3_word;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign ram_in3 = pipe3[2];

    // Reset values of every output on both instances.
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", busy1); end
        checks++; if (we1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_we got=%b exp=0", we1); end
        checks++; if (ram_address1 !== 16'h0000) begin errors++; $display("[TB] FAIL reset_addr got=%h exp=0000", ram_address1); end
        checks++; if (ram_out1 !== 16'h0000) begin errors++; $display("[TB] FAIL reset_ram_out got=%h exp=0000", ram_out1); end
        checks++; if ({a0.ack, a1.ack} !== 2'b00) begin errors++; $display("[TB] FAIL reset_acks got=%b exp=00", {a0.ack, a1.ack}); end
        checks++; if (a0.rdata !== 16'h0000) begin errors++; $display("[TB] FAIL reset_m0_rdata got=%h exp=0000", a0.rdata); end
        checks++; if (a1.rdata !== 16'h0000) begin errors++; $display("[TB] FAIL reset_m1_rdata got=%h exp=0000", a1.rdata); end
        checks++; if (busy3 !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy3 got=%b exp=0", busy3); end
        rst = 1'b0;
    endtask

    // m0 write 0xBEEF to 0x0005: one we cycle at k=1, ack at k=2, m1 silent.
    task automatic test_write();
        int   ack_k, we_cnt;
        logic we_ok, other_ack;
        ack_k = 0; we_cnt = 0; we_ok = 1'b1; other_ack = 1'b0;
        a0.req = 1'b1; a0.we = 1'b1; a0.addr = 16'h0005; a0.wdata = 16'hBEEF;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (we1) begin
                we_cnt++;
                if (k != 1 || ram_address1 !== 16'h0005 || ram_out1 !== 16'hBEEF) we_ok = 1'b0;
            end
            if (a1.ack) other_ack = 1'b1;
            if (a0.ack && ack_k == 0) begin
                ack_k = k;
                a0.req = 1'b0; a0.we = 1'b0;
            end
        end
        checks++; if (ack_k != 2) begin errors++; $display("[TB] FAIL write_ack_cycle got=%0d exp=2", ack_k); end
        checks++; if (we_cnt != 1) begin errors++; $display("[TB] FAIL write_we_cycles got=%0d exp=1", we_cnt); end
        checks++; if (we_ok !== 1'b1) begin errors++; $display("[TB] FAIL write_bus_values got=%b exp=1", we_ok); end
        checks++; if (other_ack !== 1'b0) begin errors++; $display("[TB] FAIL write_m1_ack got=%b exp=0", other_ack); end
    endtask

    // m1 reads 0x0005 back: ack at k=3 with 0xBEEF, no we, m0 rdata untouched.
    task automatic test_read();
        int          ack_k;
        logic [15:0] got;
        logic        we_seen;
        ack_k = 0; got = 16'h0000; we_seen = 1'b0;
        a1.req = 1'b1; a1.we = 1'b0; a1.addr = 16'h0005; a1.wdata = 16'h0000;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (we1) we_seen = 1'b1;
            if (a1.ack && ack_k == 0) begin
                ack_k = k;
                got = a1.rdata;
                a1.req = 1'b0;
            end
        end
        checks++; if (ack_k != 3) begin errors++; $display("[TB] FAIL read_ack_cycle got=%0d exp=3", ack_k); end
        checks++; if (got !== 16'hBEEF) begin errors++; $display("[TB] FAIL read_rdata got=%h exp=beef", got); end
        checks++; if (we_seen !== 1'b0) begin errors++; $display("[TB] FAIL read_we got=%b exp=0", we_seen); end
        checks++; if (a0.rdata !== 16'h0000) begin errors++; $display("[TB] FAIL read_m0_rdata_hold got=%h exp=0000", a0.rdata); end
    endtask

    // Both ports request continuously for 4 writes each.
    task automatic test_back_to_back();
        logic order [0:7];
        int   n, c0, c1;
        logic saw_idle, gap_ok, exp_id;
        n = 0; c0 = 0; c1 = 0; saw_idle = 1'b1; gap_ok = 1'b1;
        for (int i = 0; i < 8; i++) order[i] = 1'b0;
        a0.req = 1'b1; a0.we = 1'b1; a0.addr = 16'h0020; a0.wdata = 16'h1111;
        a1.req = 1'b1; a1.we = 1'b1; a1.addr = 16'h0040; a1.wdata = 16'h2222;
        for (int k = 0; k < 60 && n < 8; k++) begin
            @(negedge clk);
            if (a0.ack || a1.ack) begin
                if (!saw_idle || (a0.ack && a1.ack)) gap_ok = 1'b0;
                saw_idle = 1'b0;
                order[n] = a1.ack;
                n++;
                if (a0.ack) begin
                    c0++; a0.addr = a0.addr + 16'h0001;
                    if (c0 == 4) a0.req = 1'b0;
                end
                if (a1.ack) begin
                    c1++; a1.addr = a1.addr + 16'h0001;
                    if (c1 == 4) a1.req = 1'b0;
                end
            end else if (!busy1) begin
                saw_idle = 1'b1;
            end
        end
        a0.req = 1'b0; a1.req = 1'b0; a0.we = 1'b0; a1.we = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (n != 8) begin errors++; $display("[TB] FAIL b2b_count got=%0d exp=8", n); end
        checks++; if (gap_ok !== 1'b1) begin errors++; $display("[TB] FAIL b2b_idle_gap got=%b exp=1", gap_ok); end
        for (int i = 0; i < 8; i++) begin
`ifdef ARB_FIXED_PRIO_EN
            exp_id = (i >= 4);
`else
            exp_id = (i % 2 == 1);
`endif
            checks++;
            if (order[i] !== exp_id) begin
                errors++; $display("[TB] FAIL b2b_grant_%0d got=%b exp=%b", i, order[i], exp_id);
            end
        end
    endtask

    // RD_LAT=3: m0 reads 0x0010; second run drops req and changes addr early.
    task automatic test_read_lat3();
        int          ack_k, wait_cnt;
        logic [15:0] got;
        val10 = 16'h1234;
        for (int run = 0; run < 2; run++) begin
            ack_k = 0; wait_cnt = 0; got = 16'h0000;
            b0.req = 1'b1; b0.we = 1'b0; b0.addr = 16'h0010; b0.wdata = 16'h0000;
            for (int k = 1; k <= 10; k++) begin
                @(negedge clk);
                if (run == 1 && k == 1) begin
                    b0.req = 1'b0; b0.addr = 16'h0011;
                end
                if (u_dut3.state == ST_WAIT_RD) wait_cnt++;
                if (b0.ack && ack_k == 0) begin
                    ack_k = k; got = b0.rdata; b0.req = 1'b0;
                end
            end
            checks++; if (ack_k != 5) begin errors++; $display("[TB] FAIL lat3_ack_cycle_run%0d got=%0d exp=5", run, ack_k); end
            checks++; if (got !== val10) begin errors++; $display("[TB] FAIL lat3_rdata_run%0d got=%h exp=%h", run, got, val10); end
            checks++; if (wait_cnt != 3) begin errors++; $display("[TB] FAIL lat3_wait_cycles_run%0d got=%0d exp=3", run, wait_cnt); end
            val10 = 16'h5678;
        end
    endtask

    // Reset during WAIT_RD aborts the read; afterwards a tie goes to port 0.
    task automatic test_reset_mid();
        logic        ack_seen, first_id, first_seen;
        int          m1_acks;
        logic [15:0] m1_got;
        ack_seen = 1'b0; first_seen = 1'b0; first_id = 1'b1; m1_acks = 0; m1_got = 16'h0000;
        a0.req = 1'b1; a0.we = 1'b0; a0.addr = 16'h0005;
        repeat (2) @(negedge clk);
        checks++; if (u_dut1.state !== ST_WAIT_RD) begin errors++; $display("[TB] FAIL rstmid_pre_state got=%0d exp=%0d", u_dut1.state, ST_WAIT_RD); end
        rst = 1'b1; a0.req = 1'b0;
        @(negedge clk);
        if (a0.ack || a1.ack) ack_seen = 1'b1;
        checks++; if (busy1 !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy got=%b exp=0", busy1); end
        checks++; if (we1 !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_we got=%b exp=0", we1); end
        checks++; if (ram_address1 !== 16'h0000) begin errors++; $display("[TB] FAIL rstmid_addr got=%h exp=0000", ram_address1); end
        checks++; if (a1.rdata !== 16'h0000) begin errors++; $display("[TB] FAIL rstmid_m1_rdata got=%h exp=0000", a1.rdata); end
        @(negedge clk);
        if (a0.ack || a1.ack) ack_seen = 1'b1;
        rst = 1'b0;
        a0.req = 1'b1; a0.we = 1'b1; a0.addr = 16'h0030; a0.wdata = 16'h0A0A;
        a1.req = 1'b1; a1.we = 1'b0; a1.addr = 16'h0005;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if ((a0.ack || a1.ack) && !first_seen) begin
                first_seen = 1'b1; first_id = a1.ack;
            end
            if (a0.ack) a0.req = 1'b0;
            if (a1.ack) begin
                m1_acks++; m1_got = a1.rdata; a1.req = 1'b0;
            end
        end
        a0.we = 1'b0;
        checks++; if (ack_seen !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_no_ack got=%b exp=0", ack_seen); end
        checks++; if (first_seen !== 1'b1 || first_id !== PORT0) begin errors++; $display("[TB] FAIL rstmid_first_tie got=%b/%b exp=1/0", first_seen, first_id); end
        checks++; if (m1_acks != 1) begin errors++; $display("[TB] FAIL rstmid_m1_acks got=%0d exp=1", m1_acks); end
        checks++; if (m1_got !== 16'hBEEF) begin errors++; $display("[TB] FAIL rstmid_m1_rdata got=%h exp=beef", m1_got); end
    endtask

    // Test sequence; all requester inputs start idle.
    initial begin
        rst = 1'b1;
        val10 = 16'h1234;
        a0.req = 1'b0; a0.we = 1'b0; a0.addr = '0; a0.wdata = '0;
        a1.req = 1'b0; a1.we = 1'b0; a1.addr = '0; a1.wdata = '0;
        b0.req = 1'b0; b0.we = 1'b0; b0.addr = '0; b0.wdata = '0;
        b1.req = 1'b0; b1.we = 1'b0; b1.addr = '0; b1.wdata = '0;
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_read_lat3();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time limit so a stuck run still terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "[TB] watchdog");
    end

endmodule
